// File: rtl/fsm_pkg.sv
// Shared definitions for the 8x8 memory control path: FSM state encoding and op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsm_pkg;

  // Fixed encoding; the memory top and tri-state buffer rely on these values.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/fsm.sv
// Memory control FSM: turns sel/op requests into valid/rw strobes for array and tri-state buffer.
// Latency: inputs sampled at edge N show on valid/rw right after edge N (outputs decoded from state reg).
// Backpressure: none; reads hold while requested, writes pulse one cycle then force one idle cycle.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset, wins over any request
//   op    - 0 = read, 1 = write; ignored when sel = 0
//   sel   - access requested this cycle
//   valid - memory access active (array enable)
//   rw    - direction, 0 = read (buffer drives out), 1 = write
module fsm
  import fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic op,
  input  logic sel,
  output logic valid,
  output logic rw
);

  state_t r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE, READ: begin
          if (!sel)               r_state <= IDLE;
          else if (op == OP_READ) r_state <= READ;
          else                    r_state <= WRITE;
        end
        // A write is a single-cycle pulse; the forced idle cycle gives the
        // array a stable cycle between back-to-back writes.
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;  // recover from the unused encoding
      endcase
    end
  end

  // Moore decode from the state register only; the unused encoding yields 0/0.
  logic w_valid;
  logic w_rw;

  always_comb begin
    w_valid = 1'b0;
    w_rw    = 1'b0;
    case (r_state)
      READ:    w_valid = 1'b1;
      WRITE: begin
        w_valid = 1'b1;
        w_rw    = 1'b1;
      end
      default: ;
    endcase
  end

  assign valid = w_valid;
  assign rw    = w_rw;

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: directed test-plan sequences followed by random stimulus,
// all compared against a behavioural model expressed in terms of the observable strobes.
module tb_fsm;

  logic clk;
  logic rst;
  logic op;
  logic sel;
  logic valid;
  logic rw;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: whether the previous cycle carried a write pulse.
  bit exp_valid;
  bit exp_rw;
  bit prev_wr;

  fsm dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .sel   (sel),
    .valid (valid),
    .rw    (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got (valid,rw)=%b, expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model rules: reset clears; the cycle after a write pulse is always idle;
  // otherwise no request -> idle, read -> held read, write -> write pulse.
  task automatic model(input bit m_rst, input bit m_sel, input bit m_op);
    if (m_rst || prev_wr || !m_sel) begin
      exp_valid = 1'b0;
      exp_rw    = 1'b0;
    end else if (m_op == 1'b0) begin
      exp_valid = 1'b1;
      exp_rw    = 1'b0;
    end else begin
      exp_valid = 1'b1;
      exp_rw    = 1'b1;
    end
    prev_wr = exp_valid && exp_rw;
  endtask

  // Apply inputs away from the edge, clock once, update model, sample 1 time unit later.
  task automatic step(input string tag, input bit s_rst, input bit s_sel, input bit s_op);
    rst = s_rst;
    sel = s_sel;
    op  = s_op;
    @(posedge clk);
    model(s_rst, s_sel, s_op);
    #1;
    check_eq(tag, {valid, rw}, {exp_valid, exp_rw});
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b1;
    op  = 1'b1;
    prev_wr = 1'b0;
    #2;

    // Reset with a write request present: reset must win on both edges.
    step("reset0", 1, 1, 1);
    check_eq("reset0_const", {valid, rw}, 2'b00);
    step("reset1", 1, 1, 1);
    check_eq("reset1_const", {valid, rw}, 2'b00);

    // Read hold for 3 edges, then deselect.
    for (int i = 0; i < 3; i++) begin
      step("read_hold", 0, 1, 0);
      check_eq("read_hold_const", {valid, rw}, 2'b10);
    end
    step("read_release", 0, 0, 0);
    check_eq("read_release_const", {valid, rw}, 2'b00);

    // Held write: (1,1),(0,0),(1,1),(0,0).
    for (int i = 0; i < 4; i++) begin
      step("write_osc", 0, 1, 1);
      check_eq("write_osc_const", {valid, rw}, (i % 2 == 0) ? 2'b11 : 2'b00);
    end

    // Read then switch to write.
    step("rd2wr_read", 0, 1, 0);
    check_eq("rd2wr_read_const", {valid, rw}, 2'b10);
    step("rd2wr_write", 0, 1, 1);
    check_eq("rd2wr_write_const", {valid, rw}, 2'b11);
    step("rd2wr_after", 0, 1, 1);
    check_eq("rd2wr_after_const", {valid, rw}, 2'b00);

    // Deselect with op toggling.
    for (int i = 0; i < 4; i++) begin
      step("deselect", 0, 0, i[0]);
      check_eq("deselect_const", {valid, rw}, 2'b00);
    end

    // Reset while reading, then a fresh request.
    step("mid_read", 0, 1, 0);
    step("rst_in_read", 1, 1, 0);
    check_eq("rst_in_read_const", {valid, rw}, 2'b00);
    step("post_rst_read", 0, 1, 0);
    check_eq("post_rst_read_const", {valid, rw}, 2'b10);

    // Reset while writing, then a fresh write request.
    step("mid_write", 0, 1, 1);
    check_eq("mid_write_const", {valid, rw}, 2'b11);
    step("rst_in_write", 1, 1, 1);
    check_eq("rst_in_write_const", {valid, rw}, 2'b00);
    step("post_rst_write", 0, 1, 1);
    check_eq("post_rst_write_const", {valid, rw}, 2'b11);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step("random", ($urandom_range(0, 31) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
